sort_e2: RTL and testbench

Two-lane streaming top-5 pre-sorter that sits directly upstream of the E3 merge stage. Each accepted beat carries one signed int8 candidate per lane (H, L). Each lane keeps a running top-5 {index, value} list over a block of beats. At block end, or on frame end, both lists are published to E3 with a one-cycle `E2_sort_en` pulse. Successive pulses are spaced far enough apart that E3 always completes its 5-iteration merge before the lists change.

---
 rtl/sort_pkg.sv | 21 ++
 rtl/topk5_insert.sv | 62 ++++++
 rtl/sort_e2.sv | 169 ++++++++++++++++
 tb/tb_sort_e2.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared E2/E3 sorter definitions: element widths, the empty-slot entry,
// the {index, value} entry type and the 5-deep list type.
package sort_pkg;

   localparam int Data_Width  = 8;
   localparam int Index_Width = 16;
   localparam int ENTRY_W     = Index_Width + Data_Width;
   localparam int TOPK        = 5;

   localparam logic [2:0] HOLDOFF = 3'd5;

   typedef struct packed {
      logic        [Index_Width-1:0] index;
      logic signed [Data_Width-1:0]  value;
   } entry_t;

   typedef entry_t [TOPK-1:0] topk_list_t;

   localparam entry_t MIN = '{index: '0, value: {1'b1, {(Data_Width-1){1'b0}}}};

endpackage

// File: rtl/topk5_insert.sv
// One lane of the top-5 pre-sorter: the registered 5-slot list plus the
// combinational view of that list with the current candidate inserted.
module topk5_insert
   import sort_pkg::*;
#(
   parameter entry_t MIN_ENTRY = MIN
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr_i,
   input  logic       ins_en_i,
   input  entry_t     entry_i,
   output topk_list_t list_o,
   output topk_list_t next_o
);

   topk_list_t list_q;
   topk_list_t list_d;
   topk_list_t ins_list;
   logic [2:0] ins_pos;
   logic       ins_hit;

   // Strictly-greater compare: ties keep the earlier entry higher, and a
   // most-negative candidate can never displace anything.
   // NOTE: combinational blocks assign every output a default first so no latch is inferred.
   always_comb begin
      ins_hit = 1'b0;
      ins_pos = 3'd0;
      for (int i = 0; i < TOPK; i++) begin
         if (!ins_hit && (entry_i.value > list_q[i].value)) begin
            ins_hit = 1'b1;
            ins_pos = 3'(i);
         end
      end
   end

   always_comb begin
      ins_list = list_q;
      if (ins_hit) begin
         for (int i = TOPK - 1; i > 0; i--) begin
            if (3'(i) > ins_pos) ins_list[i] = list_q[i-1];
         end
         ins_list[ins_pos] = entry_i;
      end
   end

   always_comb begin
      list_d = list_q;
      if (clr_i)         list_d = {TOPK{MIN_ENTRY}};
      else if (ins_en_i) list_d = ins_list;
   end

   // NOTE: sequential state uses non-blocking assignments; the list is plain flops, so it is reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) list_q <= {TOPK{MIN_ENTRY}};
      else        list_q <= list_d;
   end

   assign list_o = list_q;
   assign next_o = ins_list;

endmodule

// File: rtl/sort_e2.sv
// Two-lane streaming top-5 pre-sorter feeding E3: beat/block counters,
// publish holdoff with deferred publish, and the published list registers.
module sort_e2
   import sort_pkg::entry_t, sort_pkg::topk_list_t, sort_pkg::TOPK, sort_pkg::HOLDOFF;
#(
   parameter int Data_Width  = 8,
   parameter int Index_Width = 16,
   parameter int BLOCK_LEN   = 16,
   parameter logic [Index_Width+Data_Width-1:0] MIN = 24'h000080
) (
   input  logic                              sys_clk,
   input  logic                              sys_rst_n,
   input  logic                              sorter_clr,
   input  logic                              data_in_valid,
   output logic                              data_in_ready,
   input  logic [Data_Width-1:0]             data_in_h,
   input  logic [Data_Width-1:0]             data_in_l,
   input  logic                              data_in_last,
   output logic [Index_Width+Data_Width-1:0] E2H_sorter_out0,
   output logic [Index_Width+Data_Width-1:0] E2H_sorter_out1,
   output logic [Index_Width+Data_Width-1:0] E2H_sorter_out2,
   output logic [Index_Width+Data_Width-1:0] E2H_sorter_out3,
   output logic [Index_Width+Data_Width-1:0] E2H_sorter_out4,
   output logic [Index_Width+Data_Width-1:0] E2L_sorter_out0,
   output logic [Index_Width+Data_Width-1:0] E2L_sorter_out1,
   output logic [Index_Width+Data_Width-1:0] E2L_sorter_out2,
   output logic [Index_Width+Data_Width-1:0] E2L_sorter_out3,
   output logic [Index_Width+Data_Width-1:0] E2L_sorter_out4,
   output logic                              E2_sort_en,
   output logic                              E2_last_sort
);

   localparam int               BLK_W    = $clog2(BLOCK_LEN);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLOCK_LEN - 1);
   localparam entry_t           MIN_E    = entry_t'(MIN);

   logic [Index_Width-2:0] b_q, b_d;
   logic [BLK_W-1:0]       blk_q, blk_d;
   logic [2:0]             holdoff_q, holdoff_d;
   logic                   pending_q, pending_d;
   logic                   last_pend_q, last_pend_d;
   logic                   ready_q, ready_d;
   logic                   sort_en_q, sort_en_d;
   logic                   last_sort_q, last_sort_d;
   topk_list_t             pub_h_q, pub_h_d;
   topk_list_t             pub_l_q, pub_l_d;

   entry_t     entry_h, entry_l;
   topk_list_t list_h, list_l, next_h, next_l;
   logic       accept, trigger, pub_now, pub_def, lane_clr;

   assign accept   = data_in_valid && ready_q;
   assign trigger  = accept && ((blk_q == BLK_LAST) || data_in_last);
   assign pub_now  = trigger && (holdoff_q == 3'd0);
   assign pub_def  = pending_q && (holdoff_q == 3'd0);
   assign lane_clr = sorter_clr || pub_now || pub_def;

   assign entry_h = entry_t'({b_q, 1'b0, data_in_h});
   assign entry_l = entry_t'({b_q, 1'b1, data_in_l});

   topk5_insert #(.MIN_ENTRY(MIN_E)) u_lane_h (
      .clk      (sys_clk),
      .rst_n    (sys_rst_n),
      .clr_i    (lane_clr),
      .ins_en_i (accept),
      .entry_i  (entry_h),
      .list_o   (list_h),
      .next_o   (next_h)
   );

   topk5_insert #(.MIN_ENTRY(MIN_E)) u_lane_l (
      .clk      (sys_clk),
      .rst_n    (sys_rst_n),
      .clr_i    (lane_clr),
      .ins_en_i (accept),
      .entry_i  (entry_l),
      .list_o   (list_l),
      .next_o   (next_l)
   );

   // An immediate publish includes the triggering beat via the lanes' next view;
   // a deferred one publishes the lists that absorbed it earlier.
   always_comb begin
      b_d         = b_q;
      blk_d       = blk_q;
      holdoff_d   = holdoff_q;
      pending_d   = pending_q;
      last_pend_d = last_pend_q;
      sort_en_d   = 1'b0;
      last_sort_d = 1'b0;
      pub_h_d     = pub_h_q;
      pub_l_d     = pub_l_q;
      if (sorter_clr) begin
         b_d         = '0;
         blk_d       = '0;
         holdoff_d   = 3'd0;
         pending_d   = 1'b0;
         last_pend_d = 1'b0;
         pub_h_d     = {TOPK{MIN_E}};
         pub_l_d     = {TOPK{MIN_E}};
      end else begin
         if (holdoff_q != 3'd0) holdoff_d = holdoff_q - 3'd1;
         if (accept) begin
            b_d   = data_in_last ? '0 : b_q + 1'b1;
            blk_d = trigger ? '0 : blk_q + 1'b1;
         end
         if (pub_now) begin
            pub_h_d     = next_h;
            pub_l_d     = next_l;
            holdoff_d   = HOLDOFF;
            sort_en_d   = 1'b1;
            last_sort_d = data_in_last;
         end else if (pub_def) begin
            pub_h_d     = list_h;
            pub_l_d     = list_l;
            holdoff_d   = HOLDOFF;
            sort_en_d   = 1'b1;
            last_sort_d = last_pend_q;
            pending_d   = 1'b0;
         end else if (trigger) begin
            pending_d   = 1'b1;
            last_pend_d = data_in_last;
         end
      end
      ready_d = !pending_d;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         b_q         <= '0;
         blk_q       <= '0;
         holdoff_q   <= 3'd0;
         pending_q   <= 1'b0;
         last_pend_q <= 1'b0;
         ready_q     <= 1'b1;
         sort_en_q   <= 1'b0;
         last_sort_q <= 1'b0;
         pub_h_q     <= {TOPK{MIN_E}};
         pub_l_q     <= {TOPK{MIN_E}};
      end else begin
         b_q         <= b_d;
         blk_q       <= blk_d;
         holdoff_q   <= holdoff_d;
         pending_q   <= pending_d;
         last_pend_q <= last_pend_d;
         ready_q     <= ready_d;
         sort_en_q   <= sort_en_d;
         last_sort_q <= last_sort_d;
         pub_h_q     <= pub_h_d;
         pub_l_q     <= pub_l_d;
      end
   end

   assign data_in_ready = ready_q;
   assign E2_sort_en    = sort_en_q;
   assign E2_last_sort  = last_sort_q;

   assign E2H_sorter_out0 = pub_h_q[0];
   assign E2H_sorter_out1 = pub_h_q[1];
   assign E2H_sorter_out2 = pub_h_q[2];
   assign E2H_sorter_out3 = pub_h_q[3];
   assign E2H_sorter_out4 = pub_h_q[4];
   assign E2L_sorter_out0 = pub_l_q[0];
   assign E2L_sorter_out1 = pub_l_q[1];
   assign E2L_sorter_out2 = pub_l_q[2];
   assign E2L_sorter_out3 = pub_l_q[3];
   assign E2L_sorter_out4 = pub_l_q[4];

endmodule

// File: tb/tb_sort_e2.sv
// Directed self-checking bench for sort_e2 with hand-computed top-5 lists,
// publish timing, deferral, clear and async reset behaviour.
module tb_sort_e2;

   localparam logic [23:0] MIN_E = 24'h000080;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic        sorter_clr;
   logic        data_in_valid;
   logic        data_in_ready;
   logic [7:0]  data_in_h;
   logic [7:0]  data_in_l;
   logic        data_in_last;
   logic [23:0] h0, h1, h2, h3, h4, l0, l1, l2, l3, l4;
   logic        E2_sort_en;
   logic        E2_last_sort;

   wire [4:0][23:0] h_out = {h4, h3, h2, h1, h0};
   wire [4:0][23:0] l_out = {l4, l3, l2, l1, l0};

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int pulse_cnt = 0;
   int ready_low_cnt = 0;
   int change_cnt = 0;
   int pulse_cyc [8];
   logic [4:0][23:0] snap_h [8];
   logic [4:0][23:0] snap_l [8];
   logic             snap_last [8];
   logic [239:0]     prev_out = '0;

   sort_e2 #(.BLOCK_LEN(16)) dut (
      .sys_clk         (sys_clk),
      .sys_rst_n       (sys_rst_n),
      .sorter_clr      (sorter_clr),
      .data_in_valid   (data_in_valid),
      .data_in_ready   (data_in_ready),
      .data_in_h       (data_in_h),
      .data_in_l       (data_in_l),
      .data_in_last    (data_in_last),
      .E2H_sorter_out0 (h0),
      .E2H_sorter_out1 (h1),
      .E2H_sorter_out2 (h2),
      .E2H_sorter_out3 (h3),
      .E2H_sorter_out4 (h4),
      .E2L_sorter_out0 (l0),
      .E2L_sorter_out1 (l1),
      .E2L_sorter_out2 (l2),
      .E2L_sorter_out3 (l3),
      .E2L_sorter_out4 (l4),
      .E2_sort_en      (E2_sort_en),
      .E2_last_sort    (E2_last_sort)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc <= cyc + 1;

   always @(negedge sys_clk) begin
      if (!data_in_ready) ready_low_cnt++;
      if (E2_sort_en) begin
         if (pulse_cnt < 8) begin
            pulse_cyc[pulse_cnt] = cyc;
            snap_h[pulse_cnt]    = h_out;
            snap_l[pulse_cnt]    = l_out;
            snap_last[pulse_cnt] = E2_last_sort;
         end
         pulse_cnt++;
      end else if ({h_out, l_out} != prev_out) begin
         change_cnt++;
      end
      prev_out = {h_out, l_out};
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] ent(input int idx, input logic [7:0] v);
      return {idx[15:0], v};
   endfunction

   task automatic tick();
      @(negedge sys_clk);
      #1;
   endtask

   task automatic do_reset();
      sys_rst_n     = 1'b0;
      sorter_clr    = 1'b0;
      data_in_valid = 1'b0;
      data_in_h     = '0;
      data_in_l     = '0;
      data_in_last  = 1'b0;
      repeat (2) tick();
      sys_rst_n = 1'b1;
      repeat (2) tick();
      pulse_cnt     = 0;
      ready_low_cnt = 0;
      change_cnt    = 0;
   endtask

   task automatic send(input logic [7:0] h, input logic [7:0] l, input logic last);
      int g = 0;
      data_in_valid = 1'b1;
      data_in_h     = h;
      data_in_l     = l;
      data_in_last  = last;
      while (!data_in_ready && g < 50) begin
         tick();
         g++;
      end
      if (g >= 50) check("ready_timeout", 64'(data_in_ready), 64'd1);
      tick();
      acc_cyc       = cyc;
      data_in_valid = 1'b0;
      data_in_last  = 1'b0;
   endtask

   task automatic send_ramp_block();
      for (int i = 0; i < 16; i++) send(8'(i), 8'(-i), 1'b0);
   endtask

   task automatic wait_pulses(input int n, input int budget);
      int g = 0;
      while (pulse_cnt < n && g < budget) begin
         tick();
         g++;
      end
      check("pulse_wait", 64'(pulse_cnt >= n), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      do_reset();
      check("rst_ready", 64'(data_in_ready), 64'd1);
      check("rst_sort_en", 64'(E2_sort_en), 64'd0);
      check("rst_last_sort", 64'(E2_last_sort), 64'd0);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("rst_h%0d", i), 64'(h_out[i]), 64'(MIN_E));
         check($sformatf("rst_l%0d", i), 64'(l_out[i]), 64'(MIN_E));
      end

      // Basic block: H = 0..15, L = -H
      send_ramp_block();
      wait_pulses(1, 10);
      repeat (3) tick();
      check("basic_pulses", 64'(pulse_cnt), 64'd1);
      check("basic_latency", 64'(pulse_cyc[0]), 64'(acc_cyc));
      check("basic_last", 64'(snap_last[0]), 64'd0);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("basic_h%0d", i), 64'(snap_h[0][i]), 64'(ent(30 - 2*i, 8'(15 - i))));
         check($sformatf("basic_l%0d", i), 64'(snap_l[0][i]), 64'(ent(1 + 2*i, 8'(-i))));
      end

      // Ties: earlier index stays higher
      do_reset();
      for (int i = 0; i < 16; i++) send(8'd5, 8'd5, 1'b0);
      repeat (8) tick();
      check("ties_pulses", 64'(pulse_cnt), 64'd1);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("ties_h%0d", i), 64'(h_out[i]), 64'(ent(2*i, 8'd5)));
         check($sformatf("ties_l%0d", i), 64'(l_out[i]), 64'(ent(2*i + 1, 8'd5)));
      end

      // Short frame right after a publish: deferred publish
      do_reset();
      send_ramp_block();
      send(8'd20, 8'hEC, 1'b0);
      send(8'hF9, 8'd100, 1'b1);
      check("short_ready_low", 64'(data_in_ready), 64'd0);
      wait_pulses(2, 20);
      check("short_spacing", 64'(pulse_cyc[1] - pulse_cyc[0]), 64'd6);
      check("short_ready_cycles", 64'(ready_low_cnt), 64'd4);
      check("short_last0", 64'(snap_last[0]), 64'd0);
      check("short_last1", 64'(snap_last[1]), 64'd1);
      check("short_h0", 64'(snap_h[1][0]), 64'(ent(32, 8'd20)));
      check("short_h1", 64'(snap_h[1][1]), 64'(ent(34, 8'hF9)));
      check("short_h2", 64'(snap_h[1][2]), 64'(MIN_E));
      check("short_h4", 64'(snap_h[1][4]), 64'(MIN_E));
      check("short_l0", 64'(snap_l[1][0]), 64'(ent(35, 8'd100)));
      check("short_l1", 64'(snap_l[1][1]), 64'(ent(33, 8'hEC)));
      check("short_l2", 64'(snap_l[1][2]), 64'(MIN_E));
      send(8'd3, 8'd4, 1'b1);
      wait_pulses(3, 20);
      check("frame2_spacing", 64'(pulse_cyc[2] - pulse_cyc[1]), 64'd6);
      check("frame2_h0", 64'(snap_h[2][0]), 64'(ent(0, 8'd3)));
      check("frame2_l0", 64'(snap_l[2][0]), 64'(ent(1, 8'd4)));
      check("frame2_h1", 64'(snap_h[2][1]), 64'(MIN_E));

      // Back-to-back blocks with continuous valid
      do_reset();
      for (int i = 0; i < 48; i++) send(8'(i), 8'(47 - i), 1'b0);
      repeat (4) tick();
      check("b2b_pulses", 64'(pulse_cnt), 64'd3);
      check("b2b_gap01", 64'(pulse_cyc[1] - pulse_cyc[0]), 64'd16);
      check("b2b_gap12", 64'(pulse_cyc[2] - pulse_cyc[1]), 64'd16);
      check("b2b_ready_low", 64'(ready_low_cnt), 64'd0);
      check("b2b_stable", 64'(change_cnt), 64'd0);
      check("b2b_h0", 64'(h0), 64'(ent(94, 8'd47)));
      check("b2b_h4", 64'(h4), 64'(ent(86, 8'd43)));
      check("b2b_l0", 64'(l0), 64'(ent(65, 8'd15)));

      // Clear mid-block drops the partial block and the same-cycle beat
      do_reset();
      send_ramp_block();
      for (int i = 0; i < 7; i++) send(8'd100, 8'd100, 1'b0);
      data_in_valid = 1'b1;
      data_in_h     = 8'd120;
      data_in_l     = 8'd120;
      sorter_clr    = 1'b1;
      tick();
      sorter_clr    = 1'b0;
      data_in_valid = 1'b0;
      repeat (3) tick();
      check("clr_pulses", 64'(pulse_cnt), 64'd1);
      check("clr_ready", 64'(data_in_ready), 64'd1);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("clr_h%0d", i), 64'(h_out[i]), 64'(MIN_E));
         check($sformatf("clr_l%0d", i), 64'(l_out[i]), 64'(MIN_E));
      end
      send(8'd9, 8'hFE, 1'b1);
      wait_pulses(2, 10);
      check("clr_next_latency", 64'(pulse_cyc[1]), 64'(acc_cyc));
      check("clr_next_h0", 64'(snap_h[1][0]), 64'(ent(0, 8'd9)));
      check("clr_next_h1", 64'(snap_h[1][1]), 64'(MIN_E));
      check("clr_next_l0", 64'(snap_l[1][0]), 64'(ent(1, 8'hFE)));
      check("clr_next_last", 64'(snap_last[1]), 64'd1);

      // Async reset while a deferred publish is pending
      do_reset();
      send_ramp_block();
      send(8'd1, 8'd1, 1'b0);
      send(8'd2, 8'd2, 1'b1);
      tick();
      check("arst_pending", 64'(data_in_ready), 64'd0);
      #2;
      sys_rst_n = 1'b0;
      #1;
      check("arst_h0", 64'(h0), 64'(MIN_E));
      check("arst_l0", 64'(l0), 64'(MIN_E));
      check("arst_sort_en", 64'(E2_sort_en), 64'd0);
      check("arst_last_sort", 64'(E2_last_sort), 64'd0);
      check("arst_ready", 64'(data_in_ready), 64'd1);
      repeat (2) tick();
      sys_rst_n = 1'b1;
      repeat (10) tick();
      check("arst_no_pulse", 64'(pulse_cnt), 64'd1);
      check("arst_ready_after", 64'(data_in_ready), 64'd1);
      check("arst_h0_after", 64'(h0), 64'(MIN_E));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
